// File: rtl/inst_fetch_rom.sv
// rtl/inst_fetch_rom.sv - PC register, instruction ROM and IF/ID pipeline register
module inst_fetch_rom #(
  parameter int    ADDR_WIDTH = 32,
  parameter int    DATA_WIDTH = 32,
  parameter int    ROM_DEPTH  = 1024,
  parameter string INIT_FILE  = "inst_rom.data"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  branch_flag,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic                  rom_ce,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] id_pc,
  output logic [DATA_WIDTH-1:0] id_inst
);

  localparam int IDX_W = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
  localparam int WIDX_W = ADDR_WIDTH - 2;
  localparam logic [WIDX_W-1:0] DEPTH_WORDS = WIDX_W'(ROM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  logic [DATA_WIDTH-1:0] inst_mem [ROM_DEPTH] = '{default: '0};

  logic unused_init_file;
  assign unused_init_file = (INIT_FILE == "");

  logic                  ce_q, ce_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] id_pc_q, id_pc_d;
  logic [DATA_WIDTH-1:0] id_inst_q, id_inst_d;
  logic [WIDX_W-1:0]     word_idx;
  logic                  idx_in_range;

  assign word_idx     = pc_q[ADDR_WIDTH-1:2];
  assign idx_in_range = (word_idx < DEPTH_WORDS);

  always_comb begin
    inst = '0;
    if (ce_q && idx_in_range) begin
      inst = inst_mem[word_idx[IDX_W-1:0]];
    end
  end

  always_comb begin
    ce_d = 1'b1;
    pc_d = pc_q;
    if (!ce_q) begin
      pc_d = '0;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (branch_flag) begin
      pc_d = branch_target;
    end else begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_comb begin
    id_pc_d   = id_pc_q;
    id_inst_d = id_inst_q;
    if (flush) begin
      id_pc_d   = '0;
      id_inst_d = '0;
    end else if (!stall) begin
      id_pc_d   = pc_q;
      id_inst_d = inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_q      <= 1'b0;
      pc_q      <= '0;
      id_pc_q   <= '0;
      id_inst_q <= '0;
    end else begin
      ce_q      <= ce_d;
      pc_q      <= pc_d;
      id_pc_q   <= id_pc_d;
      id_inst_q <= id_inst_d;
    end
  end

  assign rom_ce    = ce_q;
  assign inst_addr = pc_q;
  assign id_pc     = id_pc_q;
  assign id_inst   = id_inst_q;

endmodule

// File: tb/tb_inst_fetch_rom.sv
// tb/tb_inst_fetch_rom.sv - scoreboard bench for inst_fetch_rom
module tb_inst_fetch_rom;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  localparam logic [31:0] W0  = 32'h34011100;
  localparam logic [31:0] W1  = 32'h34020020;
  localparam logic [31:0] W2  = 32'h3403000a;
  localparam logic [31:0] W3  = 32'h3404000b;
  localparam logic [31:0] M8  = 32'h24050008;
  localparam logic [31:0] M9  = 32'h24060009;
  localparam logic [31:0] MLS = 32'hdeadbeef;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0;
  logic          flush = 1'b0;
  logic          branch_flag = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          rom_ce;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst;
  logic [AW-1:0] id_pc;
  logic [DW-1:0] id_inst;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        ce;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] idpc;
    logic [31:0] idinst;
  } exp_t;

  exp_t exp_q[$];

  inst_fetch_rom #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .ROM_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .flush        (flush),
    .branch_flag  (branch_flag),
    .branch_target(branch_target),
    .rom_ce       (rom_ce),
    .inst_addr    (inst_addr),
    .inst         (inst),
    .id_pc        (id_pc),
    .id_inst      (id_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    end
  endtask

  // Monitor: after every edge, compare DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "rom_ce", {31'b0, rom_ce}, {31'b0, e.ce});
      chk(e.name, "inst_addr", inst_addr, e.addr);
      chk(e.name, "inst", inst, e.inst);
      chk(e.name, "id_pc", id_pc, e.idpc);
      chk(e.name, "id_inst", id_inst, e.idinst);
    end
  end

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input string name, input logic r, input logic s, input logic f,
                      input logic b, input logic [31:0] t,
                      input logic ece, input logic [31:0] eaddr, input logic [31:0] einst,
                      input logic [31:0] eidpc, input logic [31:0] eidinst);
    exp_t e;
    @(negedge clk);
    rst_n = r; stall = s; flush = f; branch_flag = b; branch_target = t;
    e.name = name; e.ce = ece; e.addr = eaddr; e.inst = einst;
    e.idpc = eidpc; e.idinst = eidinst;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) dut.inst_mem[i] = '0;
    dut.inst_mem[0]       = W0;
    dut.inst_mem[1]       = W1;
    dut.inst_mem[2]       = W2;
    dut.inst_mem[3]       = W3;
    dut.inst_mem[8]       = M8;
    dut.inst_mem[9]       = M9;
    dut.inst_mem[DEPTH-1] = MLS;

    //    name          rst st fl br target        ce addr          inst id_pc         id_inst
    step("reset0",      0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0, 32'h0,        32'h0);
    step("reset1",      0, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0, 32'h0,        32'h0);
    step("edge1",       1, 0, 0, 0, 32'h0,        1, 32'h0,        W0,    32'h0,        32'h0);
    step("edge2",       1, 0, 0, 0, 32'h0,        1, 32'h4,        W1,    32'h0,        W0);
    step("edge3",       1, 0, 0, 0, 32'h0,        1, 32'h8,        W2,    32'h4,        W1);
    step("stall_a",     1, 1, 0, 0, 32'h0,        1, 32'h8,        W2,    32'h4,        W1);
    step("stall_b",     1, 1, 0, 0, 32'h0,        1, 32'h8,        W2,    32'h4,        W1);
    step("stall_c",     1, 1, 0, 0, 32'h0,        1, 32'h8,        W2,    32'h4,        W1);
    step("unstall",     1, 0, 0, 0, 32'h0,        1, 32'hC,        W3,    32'h8,        W2);
    step("branch20",    1, 0, 0, 1, 32'h20,       1, 32'h20,       M8,    32'hC,        W3);
    step("after_br",    1, 0, 0, 0, 32'h0,        1, 32'h24,       M9,    32'h20,       M8);
    step("br_stalled",  1, 1, 0, 1, 32'h40,       1, 32'h24,       M9,    32'h20,       M8);
    step("br_released", 1, 0, 0, 1, 32'h40,       1, 32'h40,       32'h0, 32'h24,       M9);
    step("flush_stall", 1, 1, 1, 0, 32'h0,        1, 32'h40,       32'h0, 32'h0,        32'h0);
    step("flush_only",  1, 0, 1, 0, 32'h0,        1, 32'h44,       32'h0, 32'h0,        32'h0);
    step("last_word",   1, 0, 0, 1, 32'hFFC,      1, 32'hFFC,      MLS,   32'h44,       32'h0);
    step("past_end",    1, 0, 0, 1, 32'h1000,     1, 32'h1000,     32'h0, 32'hFFC,      MLS);
    step("past_end4",   1, 0, 0, 0, 32'h0,        1, 32'h1004,     32'h0, 32'h1000,     32'h0);
    step("top_addr",    1, 0, 0, 1, 32'hFFFFFFFC, 1, 32'hFFFFFFFC, 32'h0, 32'h1004,     32'h0);
    step("wrap",        1, 0, 0, 0, 32'h0,        1, 32'h0,        W0,    32'hFFFFFFFC, 32'h0);
    step("misalign",    1, 0, 0, 1, 32'h6,        1, 32'h6,        W1,    32'h0,        W0);
    step("misalign4",   1, 0, 0, 0, 32'h0,        1, 32'hA,        W2,    32'h6,        W1);
    step("mid_reset",   0, 1, 1, 1, 32'h20,       0, 32'h0,        32'h0, 32'h0,        32'h0);
    step("restart1",    1, 0, 0, 0, 32'h0,        1, 32'h0,        W0,    32'h0,        32'h0);
    step("restart2",    1, 0, 0, 0, 32'h0,        1, 32'h4,        W1,    32'h0,        W0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
